vertex_face_receiver: RTL and testbench

Per-core receive stage that sits directly downstream of the vertex arbiter, one instance per render core (87 total). It snoops the shared vertex bus, captures the 24 words addressed to its own core ID into a two-bank face buffer, and drives that core's `vertex_request` and `vertex_read_done` lines back to the arbiter. A completed face is presented to the core's geometry pipeline through a valid/ready handshake with random word access.

---
 rtl/render_pkg.sv | 16 +
 rtl/face_bank_ram.sv | 35 +++
 rtl/vertex_face_receiver.sv | 136 +++++++++++++
 tb/tb_vertex_face_receiver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared render-core types and sizes for the vertex bus receive path.
package render_pkg;

   localparam int unsigned NUM_CORES      = 87;
   localparam int unsigned CORE_ID_W      = 7;
   localparam int unsigned WORDS_PER_FACE = 24;
   localparam int unsigned VERTEX_WORD_W  = 32;
   localparam int unsigned FACE_ADDR_W    = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } rx_state_t;

endpackage

// File: rtl/face_bank_ram.sv
// Two-bank face storage: one synchronous write port, one asynchronous read port.
module face_bank_ram
   import render_pkg::*;
#(
   parameter int unsigned DEPTH = WORDS_PER_FACE
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_we,
   input  logic                     i_wr_bank,
   input  logic [FACE_ADDR_W-1:0]   i_wr_addr,
   input  logic [VERTEX_WORD_W-1:0] i_wr_data,
   input  logic                     i_rd_bank,
   input  logic [FACE_ADDR_W-1:0]   i_rd_addr,
   output logic [VERTEX_WORD_W-1:0] o_rd_data
);

   logic [VERTEX_WORD_W-1:0] r_mem [2][DEPTH];

   // Cleared on reset so the consumer read port shows zeros straight out of reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
               r_mem[b][w] <= '0;
            end
         end
      end else if (i_we && (32'(i_wr_addr) < DEPTH)) begin
         r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = (32'(i_rd_addr) < DEPTH) ? r_mem[i_rd_bank][i_rd_addr] : '0;

endmodule

// File: rtl/vertex_face_receiver.sv
// Per-core vertex bus snooper: captures faces addressed to CORE_ID into a
// double-buffered face store and handshakes them to the geometry pipeline.
module vertex_face_receiver #(
   parameter int unsigned CORE_ID        = 0,
   parameter int unsigned WORDS_PER_FACE = render_pkg::WORDS_PER_FACE,
   parameter int unsigned ID_W           = render_pkg::CORE_ID_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [render_pkg::VERTEX_WORD_W-1:0] vertex_data,
   input  logic [ID_W-1:0]                      target_core_id,
   input  logic                                 vertex_valid,
   output logic                                 vertex_request,
   output logic                                 vertex_read_done,
   output logic                                 face_valid,
   input  logic                                 face_ready,
   input  logic [render_pkg::FACE_ADDR_W-1:0]   face_rd_addr,
   output logic [render_pkg::VERTEX_WORD_W-1:0] face_rd_data,
   output logic                                 overflow
);

   import render_pkg::rx_state_t;
   import render_pkg::IDLE;
   import render_pkg::RECV;
   import render_pkg::DONE;

   localparam int unsigned AW = render_pkg::FACE_ADDR_W;
   localparam logic [AW-1:0] LAST_WORD = AW'(WORDS_PER_FACE - 1);

   rx_state_t     r_state;
   rx_state_t     w_state_next;
   logic [1:0]    r_bank_full;
   logic [1:0]    w_bank_full_next;
   logic          r_wr_bank;
   logic          w_wr_bank_next;
   logic          r_rd_bank;
   logic          w_rd_bank_next;
   logic [AW-1:0] r_word_cnt;
   logic [AW-1:0] w_word_cnt_next;
   logic          r_request;
   logic          r_read_done;
   logic          r_face_valid;
   logic          r_overflow;

   logic          w_hit;
   logic          w_accept;
   logic          w_drop;
   logic          w_last;
   logic          w_release;

   // Unsolicited faces are accepted too: acceptance ignores vertex_request.
   assign w_hit     = vertex_valid && (target_core_id == ID_W'(CORE_ID));
   assign w_accept  = w_hit && !r_bank_full[r_wr_bank];
   assign w_drop    = w_hit && r_bank_full[r_wr_bank];
   assign w_last    = w_accept && (r_word_cnt == LAST_WORD);
   assign w_release = r_bank_full[r_rd_bank] && face_ready;

   // Completion targets an empty bank and release a full one, so both may apply together.
   always_comb begin
      w_state_next     = r_state;
      w_bank_full_next = r_bank_full;
      w_wr_bank_next   = r_wr_bank;
      w_rd_bank_next   = r_rd_bank;
      w_word_cnt_next  = r_word_cnt;

      if (w_accept) begin
         if (w_last) begin
            w_word_cnt_next             = '0;
            w_bank_full_next[r_wr_bank] = 1'b1;
            w_wr_bank_next              = ~r_wr_bank;
         end else begin
            w_word_cnt_next = r_word_cnt + AW'(1);
         end
      end

      if (w_release) begin
         w_bank_full_next[r_rd_bank] = 1'b0;
         w_rd_bank_next              = ~r_rd_bank;
      end

      case (r_state)
         IDLE: if (w_accept) w_state_next = w_last ? DONE : RECV;
         RECV: if (w_last)   w_state_next = DONE;
         DONE: begin
            if (w_accept) w_state_next = w_last ? DONE : RECV;
            else          w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_bank_full  <= 2'b00;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_word_cnt   <= '0;
         r_request    <= 1'b0;
         r_read_done  <= 1'b0;
         r_face_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_bank_full  <= w_bank_full_next;
         r_wr_bank    <= w_wr_bank_next;
         r_rd_bank    <= w_rd_bank_next;
         r_word_cnt   <= w_word_cnt_next;
         r_request    <= (w_state_next == IDLE) && (w_word_cnt_next == '0) &&
                         (w_bank_full_next != 2'b11);
         r_read_done  <= (w_state_next == DONE);
         r_face_valid <= w_bank_full_next[w_rd_bank_next];
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   assign vertex_request   = r_request;
   assign vertex_read_done = r_read_done;
   assign face_valid       = r_face_valid;
   assign overflow         = r_overflow;

   face_bank_ram #(
      .DEPTH (WORDS_PER_FACE)
   ) u_face_bank_ram (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_we      (w_accept),
      .i_wr_bank (r_wr_bank),
      .i_wr_addr (r_word_cnt),
      .i_wr_data (vertex_data),
      .i_rd_bank (r_rd_bank),
      .i_rd_addr (face_rd_addr),
      .o_rd_data (face_rd_data)
   );

endmodule

// File: tb/tb_vertex_face_receiver.sv
// Directed bench for vertex_face_receiver; face completions are checked by a scoreboard monitor.
module tb_vertex_face_receiver;

   localparam int unsigned CORE_ID = 0;
   localparam int unsigned ID_W    = 7;

   logic        clk;
   logic        rst;
   logic [31:0] vertex_data;
   logic [6:0]  target_core_id;
   logic        vertex_valid;
   logic        vertex_request;
   logic        vertex_read_done;
   logic        face_valid;
   logic        face_ready;
   logic [4:0]  face_rd_addr;
   logic [31:0] face_rd_data;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected overflow level at each vertex_read_done pulse.
   logic exp_q[$];

   vertex_face_receiver #(
      .CORE_ID        (CORE_ID),
      .WORDS_PER_FACE (24),
      .ID_W           (ID_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .vertex_data      (vertex_data),
      .target_core_id   (target_core_id),
      .vertex_valid     (vertex_valid),
      .vertex_request   (vertex_request),
      .vertex_read_done (vertex_read_done),
      .face_valid       (face_valid),
      .face_ready       (face_ready),
      .face_rd_addr     (face_rd_addr),
      .face_rd_data     (face_rd_data),
      .overflow         (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [6:0] id, input logic [31:0] d);
      vertex_valid   = 1'b1;
      target_core_id = id;
      vertex_data    = d;
      tick();
      vertex_valid   = 1'b0;
   endtask

   // Sends words first..last of a face for this core, values base+i.
   task automatic send_words(input logic [31:0] base, input int first, input int last);
      for (int i = first; i <= last; i++) send_word(7'(CORE_ID), base + 32'(i));
   endtask

   task automatic read_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
      face_rd_addr = addr;
      #1;
      check(name, face_rd_data, exp);
   endtask

   // Scoreboard monitor: every done pulse must match a queued completion.
   initial begin
      logic e;
      forever begin
         @(negedge clk);
         if (vertex_read_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               check("done_face_valid", 32'(face_valid), 32'd1);
               check("done_overflow", 32'(overflow), 32'(e));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; vertex_data = '0; target_core_id = '0; vertex_valid = 1'b0;
      face_ready = 1'b0; face_rd_addr = '0;
      repeat (3) tick();
      check("rst_request", 32'(vertex_request), 32'd0);
      check("rst_done", 32'(vertex_read_done), 32'd0);
      check("rst_face_valid", 32'(face_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      read_check("rst_rd_data", 5'd5, 32'd0);
      rst = 1'b0;
      tick();
      check("req_after_rst", 32'(vertex_request), 32'd1);

      // Face A into bank 0
      send_word(7'(CORE_ID), 32'h100);
      check("req_drop_w0", 32'(vertex_request), 32'd0);
      send_words(32'h100, 1, 22);
      exp_q.push_back(1'b0);
      send_word(7'(CORE_ID), 32'h117);
      check("a_done", 32'(vertex_read_done), 32'd1);
      check("a_face_valid", 32'(face_valid), 32'd1);
      tick();
      check("a_done_one_cycle", 32'(vertex_read_done), 32'd0);
      check("a_req_back", 32'(vertex_request), 32'd1);
      read_check("a_rd5", 5'd5, 32'h105);
      read_check("a_rd23", 5'd23, 32'h117);
      read_check("a_rd24_oob", 5'd24, 32'd0);

      // Traffic for another core is ignored
      for (int i = 0; i < 24; i++) send_word(7'(CORE_ID + 1), 32'h200 + 32'(i));
      check("other_req", 32'(vertex_request), 32'd1);
      check("other_ovf", 32'(overflow), 32'd0);
      read_check("other_rd0", 5'd0, 32'h100);

      // Face B into bank 1: both banks full
      exp_q.push_back(1'b0);
      send_words(32'h300, 0, 23);
      tick();
      check("b_req_full", 32'(vertex_request), 32'd0);
      check("b_face_valid", 32'(face_valid), 32'd1);
      read_check("b_rd_bank0", 5'd5, 32'h105);

      // Release bank 0; bank 1 becomes visible
      face_ready = 1'b1;
      tick();
      face_ready = 1'b0;
      check("rel_face_valid", 32'(face_valid), 32'd1);
      check("rel_req", 32'(vertex_request), 32'd1);
      read_check("rel_rd5", 5'd5, 32'h305);

      // Face C completes in the same cycle bank 1 is released
      send_words(32'h400, 0, 22);
      exp_q.push_back(1'b0);
      face_ready = 1'b1;
      send_word(7'(CORE_ID), 32'h417);
      face_ready = 1'b0;
      check("c_done", 32'(vertex_read_done), 32'd1);
      check("c_ovf", 32'(overflow), 32'd0);
      check("c_face_valid", 32'(face_valid), 32'd1);
      read_check("c_rd5", 5'd5, 32'h405);
      tick();
      check("c_req", 32'(vertex_request), 32'd1);

      // Face D fills bank 1, then a 49th word is dropped
      exp_q.push_back(1'b0);
      send_words(32'h700, 0, 23);
      tick();
      check("d_req_full", 32'(vertex_request), 32'd0);
      send_word(7'(CORE_ID), 32'hDEAD);
      check("drop_ovf", 32'(overflow), 32'd1);
      read_check("drop_rd5", 5'd5, 32'h405);
      read_check("drop_rd0", 5'd0, 32'h400);

      // Drain both banks
      face_ready = 1'b1;
      tick();
      check("drain1_face_valid", 32'(face_valid), 32'd1);
      read_check("drain1_rd5", 5'd5, 32'h705);
      tick();
      face_ready = 1'b0;
      check("drain2_face_valid", 32'(face_valid), 32'd0);
      check("drain2_req", 32'(vertex_request), 32'd1);

      // Reset in the middle of a face
      send_words(32'h500, 0, 10);
      rst = 1'b1;
      tick();
      check("mid_rst_request", 32'(vertex_request), 32'd0);
      check("mid_rst_done", 32'(vertex_read_done), 32'd0);
      check("mid_rst_face_valid", 32'(face_valid), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      read_check("mid_rst_rd5", 5'd5, 32'd0);
      rst = 1'b0;
      tick();
      check("mid_rst_req_back", 32'(vertex_request), 32'd1);

      // Fresh face after reset
      exp_q.push_back(1'b0);
      send_words(32'h600, 0, 23);
      check("e_done", 32'(vertex_read_done), 32'd1);
      check("e_face_valid", 32'(face_valid), 32'd1);
      read_check("e_rd0", 5'd0, 32'h600);
      read_check("e_rd10", 5'd10, 32'h60A);
      read_check("e_rd23", 5'd23, 32'h617);

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
